// File: rtl/pmem_rd_arbiter_pkg.sv
// Shared owner encoding and sizing helper for the packet-memory read arbiter.
// Owner tags travel through the tag FIFO as a single bit.
package pmem_rd_arbiter_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_FWD = 1'b1
  } owner_e;

  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_TAG_DEPTH  = 4;
  localparam int DEF_MAX_BURST  = 8;

  // Bits needed to hold values 0..n-1 (minimum 1).
  function automatic int ptr_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/pmem_rd_arbiter_if.sv
// Requester and packet-memory signals of the read arbiter, bundled per side.
// slave = arbiter view; master = requesters plus memory.
interface pmem_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
);
  logic                  cpu_rd_en;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_gnt;
  logic [DATA_WIDTH-1:0] cpu_data;
  logic                  cpu_data_vld;

  logic                  fwd_rd_en;
  logic [ADDR_WIDTH-1:0] fwd_addr;
  logic                  fwd_burst;
  logic                  fwd_gnt;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  fwd_data_vld;

  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_data_vld;
  logic                  rsp_err;

  modport slave (
    input  cpu_rd_en, cpu_addr, fwd_rd_en, fwd_addr, fwd_burst, mem_data, mem_data_vld,
    output cpu_gnt, cpu_data, cpu_data_vld, fwd_gnt, fwd_data, fwd_data_vld,
           mem_rd_en, mem_addr, rsp_err
  );

  modport master (
    output cpu_rd_en, cpu_addr, fwd_rd_en, fwd_addr, fwd_burst, mem_data, mem_data_vld,
    input  cpu_gnt, cpu_data, cpu_data_vld, fwd_gnt, fwd_data, fwd_data_vld,
           mem_rd_en, mem_addr, rsp_err
  );
endinterface

// File: rtl/pmem_rd_arbiter_tag_fifo.sv
// Generic small FIFO holding in-flight read owner tags; DEPTH must be a power of 2.
// Registered full/empty; push while full and pop while empty are ignored.
module pmem_tag_fifo
  import pmem_rd_arbiter_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = ptr_w(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;
  assign o_pop_dat = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/pmem_rd_arbiter.sv
// Shares the packet-memory read port between CPU and forwarder; responses return in issue order.
// Grant is combinational, memory request one cycle later, data one cycle after mem_data_vld; no grant while tags are full.
module pmem_rd_arbiter
  import pmem_rd_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAG_DEPTH  = DEF_TAG_DEPTH,
  parameter int CPU_PRIO   = 0,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  pmem_rd_arbiter_if.slave io_bus
);
  localparam int BW = ptr_w(MAX_BURST + 1);

  owner_e                r_last_owner;
  logic                  r_last_burst;
  logic [BW-1:0]         r_burst_cnt;
  logic                  r_mem_rd_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_cpu_data;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic                  r_cpu_data_vld;
  logic                  r_fwd_data_vld;
  logic                  r_rsp_err;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_lock;
  logic                  w_burst_max;
  logic                  w_cpu_sel;
  logic                  w_cpu_gnt;
  logic                  w_fwd_gnt;
  logic                  w_push;
  owner_e                w_push_own;
  logic                  w_pop;
  logic                  w_pop_dat;
  owner_e                w_pop_own;

  assign w_lock      = (r_last_owner == OWN_FWD) && r_last_burst;
  assign w_burst_max = (r_burst_cnt == BW'(MAX_BURST));

  always_comb begin
    w_cpu_sel = 1'b0;
    if (io_bus.cpu_rd_en) begin
      if (!io_bus.fwd_rd_en)  w_cpu_sel = 1'b1;
      else if (w_lock)        w_cpu_sel = w_burst_max;
      else if (CPU_PRIO != 0) w_cpu_sel = 1'b1;
      else                    w_cpu_sel = (r_last_owner == OWN_FWD);
    end
  end

  assign w_cpu_gnt  = !w_full && w_cpu_sel;
  assign w_fwd_gnt  = !w_full && io_bus.fwd_rd_en && !w_cpu_sel;
  assign w_push     = w_cpu_gnt || w_fwd_gnt;
  assign w_push_own = w_fwd_gnt ? OWN_FWD : OWN_CPU;
  assign w_pop      = io_bus.mem_data_vld && !w_empty;
  assign w_pop_own  = owner_e'(w_pop_dat);

  pmem_tag_fifo #(
    .WIDTH (1),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_push_dat (w_push_own),
    .i_pop      (w_pop),
    .o_pop_dat  (w_pop_dat),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last_owner   <= OWN_FWD;
      r_last_burst   <= 1'b0;
      r_burst_cnt    <= '0;
      r_mem_rd_en    <= 1'b0;
      r_mem_addr     <= '0;
      r_cpu_data     <= '0;
      r_fwd_data     <= '0;
      r_cpu_data_vld <= 1'b0;
      r_fwd_data_vld <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else begin
      r_mem_rd_en <= w_push;
      if (w_cpu_gnt)      r_mem_addr <= io_bus.cpu_addr;
      else if (w_fwd_gnt) r_mem_addr <= io_bus.fwd_addr;

      // The grant that opens a burst counts toward MAX_BURST.
      if (w_cpu_gnt) begin
        r_last_owner <= OWN_CPU;
        r_last_burst <= 1'b0;
        r_burst_cnt  <= '0;
      end else if (w_fwd_gnt) begin
        r_last_owner <= OWN_FWD;
        r_last_burst <= io_bus.fwd_burst;
        if (!io_bus.fwd_burst)  r_burst_cnt <= '0;
        else if (!w_burst_max)  r_burst_cnt <= r_burst_cnt + BW'(1);
      end

      r_cpu_data_vld <= w_pop && (w_pop_own == OWN_CPU);
      r_fwd_data_vld <= w_pop && (w_pop_own == OWN_FWD);
      if (w_pop && (w_pop_own == OWN_CPU)) r_cpu_data <= io_bus.mem_data;
      if (w_pop && (w_pop_own == OWN_FWD)) r_fwd_data <= io_bus.mem_data;

      if (io_bus.mem_data_vld && w_empty) r_rsp_err <= 1'b1;
    end
  end

  assign io_bus.cpu_gnt      = w_cpu_gnt;
  assign io_bus.fwd_gnt      = w_fwd_gnt;
  assign io_bus.mem_rd_en    = r_mem_rd_en;
  assign io_bus.mem_addr     = r_mem_addr;
  assign io_bus.cpu_data     = r_cpu_data;
  assign io_bus.cpu_data_vld = r_cpu_data_vld;
  assign io_bus.fwd_data     = r_fwd_data;
  assign io_bus.fwd_data_vld = r_fwd_data_vld;
  assign io_bus.rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_pmem_rd_arbiter.sv
// Directed bench for pmem_rd_arbiter with a fixed-latency memory model and manual response injection.
module tb_pmem_rd_arbiter;
  localparam int AW = 9;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmem_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  pmem_rd_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TAG_DEPTH  (4),
    .CPU_PRIO   (0),
    .MAX_BURST  (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  // Memory: mem_data_vld appears two cycles after the cycle mem_rd_en is high.
  logic          mem_auto = 1'b1;
  logic          man_vld  = 1'b0;
  logic [DW-1:0] man_dat  = '0;
  logic          s0_v = 1'b0, s1_v = 1'b0, s2_v = 1'b0;
  logic [AW-1:0] s0_a = '0, s1_a = '0, s2_a = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 64'h0123_4567_89AB_CDEF ^ {55'd0, a ^ 9'h00D};
  endfunction

  always @(negedge clk) begin
    s2_v = s1_v; s2_a = s1_a;
    s1_v = s0_v; s1_a = s0_a;
    s0_v = bus.mem_rd_en & mem_auto; s0_a = bus.mem_addr;
  end

  assign bus.mem_data_vld = s2_v | man_vld;
  assign bus.mem_data     = s2_v ? mem_word(s2_a) : man_dat;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.cpu_rd_en = 1'b0;
    bus.fwd_rd_en = 1'b0;
    bus.fwd_burst = 1'b0;
    man_vld       = 1'b0;
    rst_n         = 1'b0;
    tick();
    rst_n         = 1'b1;
  endtask

  logic          q_own [$];
  logic [AW-1:0] q_addr[$];
  logic          e_own;
  logic [AW-1:0] e_addr;
  logic [AW-1:0] ca, fa;
  logic [DW-1:0] last_cpu, last_fwd;

  initial begin
    bus.cpu_rd_en = 1'b0;
    bus.cpu_addr  = '0;
    bus.fwd_rd_en = 1'b0;
    bus.fwd_addr  = '0;
    bus.fwd_burst = 1'b0;

    // Reset state
    tick(); tick();
    #1;
    chk("rst_mem_rd_en",   64'(bus.mem_rd_en),    64'(1'b0));
    chk("rst_mem_addr",    64'(bus.mem_addr),     64'(9'h000));
    chk("rst_cpu_vld",     64'(bus.cpu_data_vld), 64'(1'b0));
    chk("rst_fwd_vld",     64'(bus.fwd_data_vld), 64'(1'b0));
    chk("rst_cpu_data",    bus.cpu_data,          64'h0);
    chk("rst_fwd_data",    bus.fwd_data,          64'h0);
    chk("rst_rsp_err",     64'(bus.rsp_err),      64'(1'b0));
    chk("rst_cpu_gnt",     64'(bus.cpu_gnt),      64'(1'b0));
    rst_n = 1'b1;

    // Single CPU read of 0x00D
    tick();
    bus.cpu_addr = 9'h00D; bus.cpu_rd_en = 1'b1; #1;
    chk("t1_cpu_gnt", 64'(bus.cpu_gnt), 64'(1'b1));
    chk("t1_fwd_gnt", 64'(bus.fwd_gnt), 64'(1'b0));
    tick(); bus.cpu_rd_en = 1'b0; #1;
    chk("t1_mem_rd_en", 64'(bus.mem_rd_en), 64'(1'b1));
    chk("t1_mem_addr",  64'(bus.mem_addr),  64'(9'h00D));
    tick(); #1;
    chk("t1_mem_rd_off", 64'(bus.mem_rd_en),    64'(1'b0));
    chk("t1_vld_early2", 64'(bus.cpu_data_vld), 64'(1'b0));
    tick(); #1;
    chk("t1_vld_early3", 64'(bus.cpu_data_vld), 64'(1'b0));
    tick(); #1;
    chk("t1_cpu_vld",  64'(bus.cpu_data_vld), 64'(1'b1));
    chk("t1_cpu_data", bus.cpu_data,          64'h0123_4567_89AB_CDEF);
    chk("t1_fwd_vld",  64'(bus.fwd_data_vld), 64'(1'b0));
    tick(); #1;
    chk("t1_vld_pulse", 64'(bus.cpu_data_vld), 64'(1'b0));

    // Round-robin alternation with in-order response routing
    tick(); do_reset();
    ca = 9'h010; fa = 9'h100; last_cpu = '0; last_fwd = '0;
    for (int c = 0; c < 11; c++) begin
      if (c < 6) begin
        bus.cpu_rd_en = 1'b1; bus.fwd_rd_en = 1'b1;
        bus.cpu_addr = ca; bus.fwd_addr = fa;
        e_own = (c % 2 == 1);
        q_own.push_back(e_own);
        q_addr.push_back(e_own ? fa : ca);
      end else begin
        bus.cpu_rd_en = 1'b0; bus.fwd_rd_en = 1'b0;
      end
      #1;
      if (c < 6) begin
        chk("alt_cpu_gnt", 64'(bus.cpu_gnt), 64'(!e_own));
        chk("alt_fwd_gnt", 64'(bus.fwd_gnt), 64'(e_own));
        if (e_own) fa = fa + 9'd1; else ca = ca + 9'd1;
      end
      if (c >= 4 && c <= 9) begin
        e_own  = q_own.pop_front();
        e_addr = q_addr.pop_front();
        if (e_own) last_fwd = mem_word(e_addr); else last_cpu = mem_word(e_addr);
        chk("alt_cpu_vld",  64'(bus.cpu_data_vld), 64'(!e_own));
        chk("alt_fwd_vld",  64'(bus.fwd_data_vld), 64'(e_own));
        chk("alt_cpu_data", bus.cpu_data, last_cpu);
        chk("alt_fwd_data", bus.fwd_data, last_fwd);
      end else begin
        chk("alt_no_cpu_vld", 64'(bus.cpu_data_vld), 64'(1'b0));
        chk("alt_no_fwd_vld", 64'(bus.fwd_data_vld), 64'(1'b0));
      end
      tick();
    end

    // Forwarder burst lock: 8 FWD grants then the waiting CPU
    do_reset();
    bus.fwd_addr = 9'h080; bus.cpu_addr = 9'h020;
    for (int c = 0; c < 10; c++) begin
      bus.fwd_rd_en = (c < 9);
      bus.fwd_burst = 1'b1;
      bus.cpu_rd_en = (c >= 2) && (c < 9);
      #1;
      if (c < 9) begin
        chk("burst_fwd_gnt", 64'(bus.fwd_gnt), 64'(c < 8));
        chk("burst_cpu_gnt", 64'(bus.cpu_gnt), 64'(c == 8));
      end
      tick();
    end
    repeat (6) tick();

    // Stalled memory: 4 grants, then one pop frees one slot a cycle later
    do_reset();
    mem_auto = 1'b0;
    bus.cpu_addr = 9'h033;
    for (int c = 0; c < 8; c++) begin
      bus.cpu_rd_en = 1'b1; #1;
      chk("stall_gnt", 64'(bus.cpu_gnt), 64'(c < 4));
      tick();
    end
    man_dat = 64'hDEAD_BEEF_0000_0001; man_vld = 1'b1; #1;
    chk("stall_pop_cycle_gnt", 64'(bus.cpu_gnt), 64'(1'b0));
    tick(); man_vld = 1'b0; #1;
    chk("stall_regrant",  64'(bus.cpu_gnt),      64'(1'b1));
    chk("stall_rsp_vld",  64'(bus.cpu_data_vld), 64'(1'b1));
    chk("stall_rsp_data", bus.cpu_data,          64'hDEAD_BEEF_0000_0001);
    tick(); #1;
    chk("stall_full_again", 64'(bus.cpu_gnt), 64'(1'b0));
    bus.cpu_rd_en = 1'b0;

    // Response with nothing outstanding
    tick(); do_reset(); #1;
    chk("err_clear", 64'(bus.rsp_err), 64'(1'b0));
    man_dat = 64'h1111_2222_3333_4444; man_vld = 1'b1;
    tick(); man_vld = 1'b0; #1;
    chk("err_set",     64'(bus.rsp_err),      64'(1'b1));
    chk("err_cpu_vld", 64'(bus.cpu_data_vld), 64'(1'b0));
    chk("err_fwd_vld", 64'(bus.fwd_data_vld), 64'(1'b0));
    repeat (3) tick(); #1;
    chk("err_sticky", 64'(bus.rsp_err), 64'(1'b1));
    tick(); do_reset(); #1;
    chk("err_reset", 64'(bus.rsp_err), 64'(1'b0));

    // Reset with 3 reads outstanding, stale responses, then a clean read
    bus.cpu_addr = 9'h044;
    for (int c = 0; c < 3; c++) begin
      bus.cpu_rd_en = 1'b1; #1;
      chk("mid_gnt", 64'(bus.cpu_gnt), 64'(1'b1));
      tick();
    end
    bus.cpu_rd_en = 1'b0; #1;
    chk("mid_mem_rd", 64'(bus.mem_rd_en), 64'(1'b1));
    do_reset(); #1;
    chk("mid_rst_mem_rd",  64'(bus.mem_rd_en),    64'(1'b0));
    chk("mid_rst_addr",    64'(bus.mem_addr),     64'(9'h000));
    chk("mid_rst_cpu_vld", 64'(bus.cpu_data_vld), 64'(1'b0));
    chk("mid_rst_data",    bus.cpu_data,          64'h0);
    chk("mid_rst_err",     64'(bus.rsp_err),      64'(1'b0));
    for (int k = 0; k < 3; k++) begin
      man_dat = 64'hAAAA_0000_0000_0000 | 64'(k); man_vld = 1'b1;
      tick(); man_vld = 1'b0; #1;
      chk("late_cpu_vld", 64'(bus.cpu_data_vld), 64'(1'b0));
      chk("late_fwd_vld", 64'(bus.fwd_data_vld), 64'(1'b0));
      chk("late_err",     64'(bus.rsp_err),      64'(1'b1));
    end
    mem_auto = 1'b1;
    tick();
    bus.cpu_addr = 9'h055; bus.cpu_rd_en = 1'b1; #1;
    chk("new_gnt", 64'(bus.cpu_gnt), 64'(1'b1));
    tick(); bus.cpu_rd_en = 1'b0;
    repeat (3) tick(); #1;
    chk("new_cpu_vld",  64'(bus.cpu_data_vld), 64'(1'b1));
    chk("new_cpu_data", bus.cpu_data,          mem_word(9'h055));
    chk("new_fwd_vld",  64'(bus.fwd_data_vld), 64'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
